sw_seq_feeder: RTL and testbench
================================

Name: sw_seq_feeder

Overview:
- Upstream stage of the affine-gap systolic PE chain; drives PE 0's s/t/s_update/valid/col inputs and the chain-wide PE_rst.
- Splits a query longer than the chain into chunks of N_PE bases.
- For each chunk: loads the query bases, streams the whole target, waits for the chain to drain, then pulses the chain reset before the next chunk.
- Reads query and target bases from two single-port sequence memories with 1-cycle read latency.

Parameters:
BP_WIDTH, 3, width of one encoded base
ADDRESS_WIDTH, 10, width of lengths, addresses and column index
N_PE, 32, number of PEs in the chain (chunk size)
DRAIN_CYCLES, N_PE+2, idle cycles after the last target base before the chunk is complete

Ports:
clk  in  1  single clock, all logic on rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse; accepted only in IDLE
query_len_i  in  ADDRESS_WIDTH  query length Lq, sampled on accepted start; 1..2^AW-1
target_len_i  in  ADDRESS_WIDTH  target length Lt, sampled on accepted start; 1..2^AW-1
q_addr_o  out  ADDRESS_WIDTH  query memory read address
q_data_i  in  BP_WIDTH  query base, valid 1 cycle after q_addr_o
t_addr_o  out  ADDRESS_WIDTH  target memory read address
t_data_i  in  BP_WIDTH  target base, valid 1 cycle after t_addr_o
s_out  out  BP_WIDTH  query base to PE 0
s_update_out  out  1  qualifies s_out
t_out  out  BP_WIDTH  target base to PE 0
valid_out  out  1  qualifies t_out
col_out  out  ADDRESS_WIDTH  query index of PE 0 for the current chunk
PE_rst_o  out  1  active-low chain reset
busy_o  out  1  high whenever not IDLE
chunk_done_o  out  1  one-cycle pulse at the end of each chunk's DRAIN
done_o  out  1  one-cycle pulse when all chunks are finished

Behaviour:
- Reset: all outputs 0 except PE_rst_o=1. State IDLE, counters 0.
- Reset asserted mid-operation aborts the run at the next edge with the same values. PE_rst_o is not pulsed.
- Chunk count C = ceil(Lq/N_PE). Chunk k has base address B=k*N_PE and length Lk=min(N_PE, Lq-B).
- States:
  - IDLE: on start_i, latch lengths, k=0 -> CRST.
  - CRST: one cycle with PE_rst_o=0 -> LOAD.
  - LOAD: issue q_addr_o = B+Lk-1 down to B, one address per cycle, Lk cycles -> LGAP.
    - Each returned base appears on s_out with s_update_out=1 one cycle later, registered, so it leaves in reverse order.
    - s_update_out is high for exactly Lk consecutive cycles.
  - LGAP: one cycle, lets the last query base leave -> STREAM.
  - STREAM: issue t_addr_o = 0..Lt-1, Lt cycles. valid_out=1 with t_out=t_data_i on the following Lt consecutive cycles.
  - DRAIN: DRAIN_CYCLES cycles, then chunk_done_o=1.
    - If k+1<C: k++ -> CRST.
    - Else: done_o=1 the same cycle -> IDLE.
- Output rules:
  - col_out = B, held constant from CRST through DRAIN, registered.
  - valid_out and s_update_out are never high in the same cycle.
  - t_out and s_out hold their last value when not qualified.
- start_i while busy_o=1 is ignored.
- Address counters are ADDRESS_WIDTH wide and never wrap, because lengths are bounded.
- Simultaneous chunk_done_o and done_o occur on the final chunk only.
- Total cycles from start to done: C*(1+Lk+1+Lt+DRAIN_CYCLES+1) with per-chunk Lk; the trailing +1 is the STREAM->DRAIN data latency cycle.

Optional Feature:
SW_FEEDER_STALL_EN
- With the macro: adds input stall_i.
- While stall_i=1, the FSM, counters and memory addresses freeze.
- valid_out and s_update_out are forced 0.
- Returned data is held in a one-entry skid register and re-presented when the stall releases, so no base is lost or duplicated.
- CRST and DRAIN counting also freeze.
- Without the macro: no port, no skid register, no stall logic.

Decomposition:
- Shared package/define file: BP_WIDTH, ADDRESS_WIDTH, N_PE, the state encoding (IDLE, CRST, LOAD, LGAP, STREAM, DRAIN), and base codes.
- One natural sub-module: sw_feeder_rd_pipe.
  - 1-cycle memory-read alignment register plus the optional skid.
  - Instantiated twice, for query and target.

Test Plan:
- Lq=4, Lt=5, N_PE=32, query ACGT:
  - s_out=T,G,C,A with s_update_out high 4 cycles.
  - One gap cycle, then valid_out high 5 cycles with t_addr 0..4.
  - col_out=0; done_o exactly 1+4+1+5+34+1=46 cycles after start.
- Lq=70, N_PE=32:
  - 3 chunks with col_out 0, 32, 64 and Lk 32, 32, 6.
  - PE_rst_o low one cycle before each LOAD; chunk_done_o 3 pulses; done_o once.
- start_i pulsed again during STREAM -> ignored, with identical output trace.
- reset_i=1 mid-STREAM -> next cycle all outputs 0, PE_rst_o=1, busy_o=0.
  - A new start then runs a full normal sequence.
- Lq=1, Lt=1 -> one s_update cycle, one valid cycle, done_o after 1+1+1+1+34+1=39 cycles.
- With SW_FEEDER_STALL_EN, stall_i high 3 cycles mid-LOAD and mid-STREAM:
  - Emitted base sequences identical to the no-stall run.
  - done_o delayed by exactly 6 cycles.

Source files
------------

// File: rtl/sw_seq_feeder_pkg.sv
// sw_seq_feeder_pkg: shared widths, chunk size, FSM encoding and base codes for the sequence feeder.
package sw_seq_feeder_pkg;
  localparam int BP_WIDTH      = 3;
  localparam int ADDRESS_WIDTH = 10;
  localparam int N_PE          = 32;
  localparam int DRAIN_CYCLES  = N_PE + 2;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CRST   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_LGAP   = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [BP_WIDTH-1:0] BASE_A = 3'd0;
  localparam logic [BP_WIDTH-1:0] BASE_C = 3'd1;
  localparam logic [BP_WIDTH-1:0] BASE_G = 3'd2;
  localparam logic [BP_WIDTH-1:0] BASE_T = 3'd3;
  localparam logic [BP_WIDTH-1:0] BASE_N = 3'd4;
endpackage

// File: rtl/sw_feeder_rd_pipe.sv
// sw_feeder_rd_pipe: aligns a 1-cycle memory read with its qualifier and holds the last base;
// with SW_FEEDER_STALL_EN a one-entry skid keeps the base that lands during a stall.
module sw_feeder_rd_pipe #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_i,
`ifdef SW_FEEDER_STALL_EN
  input  logic         stall_i,
`endif
  input  logic         issue_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         vld_o
);
  logic         vld_q;
  logic [W-1:0] hold_q;
`ifdef SW_FEEDER_STALL_EN
  logic         skid_full_q;
  logic [W-1:0] skid_q;
  logic [W-1:0] cur;
  assign cur    = skid_full_q ? skid_q : data_i;
  assign vld_o  = vld_q & ~stall_i;
  assign data_o = vld_o ? cur : hold_q;
  always_ff @(posedge clk) begin
    if (rst_i) begin
      vld_q       <= 1'b0;
      hold_q      <= '0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else if (stall_i) begin
      if (vld_q && !skid_full_q) begin
        skid_q      <= data_i;
        skid_full_q <= 1'b1;
      end
    end else begin
      vld_q       <= issue_i;
      skid_full_q <= 1'b0;
      if (vld_q) hold_q <= cur;
    end
  end
`else
  assign vld_o  = vld_q;
  assign data_o = vld_q ? data_i : hold_q;
  always_ff @(posedge clk) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      vld_q <= issue_i;
      if (vld_q) hold_q <= data_i;
    end
  end
`endif
endmodule

// File: rtl/sw_seq_feeder.sv
// sw_seq_feeder: chunks the query into N_PE-base loads, streams the target per chunk and resets the PE chain between chunks.
// Optional SW_FEEDER_STALL_EN adds stall_i, which freezes the sequencer and masks the output qualifiers.
module sw_seq_feeder
  import sw_seq_feeder_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     start_i,
`ifdef SW_FEEDER_STALL_EN
  input  logic                     stall_i,
`endif
  input  logic [ADDRESS_WIDTH-1:0] query_len_i,
  input  logic [ADDRESS_WIDTH-1:0] target_len_i,
  output logic [ADDRESS_WIDTH-1:0] q_addr_o,
  input  logic [BP_WIDTH-1:0]      q_data_i,
  output logic [ADDRESS_WIDTH-1:0] t_addr_o,
  input  logic [BP_WIDTH-1:0]      t_data_i,
  output logic [BP_WIDTH-1:0]      s_out,
  output logic                     s_update_out,
  output logic [BP_WIDTH-1:0]      t_out,
  output logic                     valid_out,
  output logic [ADDRESS_WIDTH-1:0] col_out,
  output logic                     PE_rst_o,
  output logic                     busy_o,
  output logic                     chunk_done_o,
  output logic                     done_o
);
  localparam logic [ADDRESS_WIDTH-1:0] NPE = ADDRESS_WIDTH'(N_PE);
  localparam logic [ADDRESS_WIDTH-1:0] DRN = ADDRESS_WIDTH'(DRAIN_CYCLES);
  logic [2:0]               st_q, st_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d, base_q, base_d, lq_q, lq_d, lt_q, lt_d;
  logic [ADDRESS_WIDTH-1:0] rem, lk, cnt_end;
  logic                     more, at_end, stall;
`ifdef SW_FEEDER_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif
  // DRAIN runs DRAIN_CYCLES+1 cycles: the first carries the last target base out of the read pipe.
  always_comb begin
    rem     = lq_q - base_q;
    more    = rem > NPE;
    lk      = more ? NPE : rem;
    cnt_end = st_q == S_LOAD ? lk - 1'b1 : st_q == S_STREAM ? lt_q - 1'b1 : st_q == S_DRAIN ? DRN : '0;
    at_end  = cnt_q == cnt_end;
    st_d    = st_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    lq_d    = lq_q;
    lt_d    = lt_q;
    if (!stall) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
      case (st_q)
        S_IDLE: if (start_i) begin
          st_d   = S_CRST;
          base_d = '0;
          lq_d   = query_len_i;
          lt_d   = target_len_i;
        end
        S_CRST:   st_d = S_LOAD;
        S_LOAD:   st_d = at_end ? S_LGAP : S_LOAD;
        S_LGAP:   st_d = S_STREAM;
        S_STREAM: st_d = at_end ? S_DRAIN : S_STREAM;
        S_DRAIN: if (at_end) begin
          st_d   = more ? S_CRST : S_IDLE;
          base_d = more ? base_q + NPE : base_q;
        end
        default:  st_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      base_q <= '0;
      lq_q   <= '0;
      lt_q   <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      base_q <= base_d;
      lq_q   <= lq_d;
      lt_q   <= lt_d;
    end
  end
  assign q_addr_o     = st_q == S_LOAD ? base_q + lk - 1'b1 - cnt_q : '0;
  assign t_addr_o     = st_q == S_STREAM ? cnt_q : '0;
  assign col_out      = base_q;
  assign PE_rst_o     = st_q != S_CRST;
  assign busy_o       = st_q != S_IDLE;
  assign chunk_done_o = st_q == S_DRAIN && at_end && !stall;
  assign done_o       = chunk_done_o && !more;
  sw_feeder_rd_pipe #(.W(BP_WIDTH)) u_q_pipe (
    .clk    (clk),
    .rst_i  (reset_i),
`ifdef SW_FEEDER_STALL_EN
    .stall_i(stall_i),
`endif
    .issue_i(st_q == S_LOAD),
    .data_i (q_data_i),
    .data_o (s_out),
    .vld_o  (s_update_out)
  );
  sw_feeder_rd_pipe #(.W(BP_WIDTH)) u_t_pipe (
    .clk    (clk),
    .rst_i  (reset_i),
`ifdef SW_FEEDER_STALL_EN
    .stall_i(stall_i),
`endif
    .issue_i(st_q == S_STREAM),
    .data_i (t_data_i),
    .data_o (t_out),
    .vld_o  (valid_out)
  );
endmodule

// File: tb/tb_sw_seq_feeder.sv
// tb_sw_seq_feeder: table-driven and randomized checks of sw_seq_feeder against a per-cycle behavioural model.
module tb_sw_seq_feeder;
  import sw_seq_feeder_pkg::*;
  localparam int AW = ADDRESS_WIDTH;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i, start_i;
  logic [AW-1:0] query_len_i, target_len_i, q_addr_o, t_addr_o, col_out;
  logic [BP_WIDTH-1:0] q_data_i, t_data_i, s_out, t_out;
  logic s_update_out, valid_out, PE_rst_o, busy_o, chunk_done_o, done_o;
`ifdef SW_FEEDER_STALL_EN
  logic stall_i = 1'b0;
`endif
  sw_seq_feeder dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i),
`ifdef SW_FEEDER_STALL_EN
    .stall_i(stall_i),
`endif
    .query_len_i(query_len_i), .target_len_i(target_len_i),
    .q_addr_o(q_addr_o), .q_data_i(q_data_i), .t_addr_o(t_addr_o), .t_data_i(t_data_i),
    .s_out(s_out), .s_update_out(s_update_out), .t_out(t_out), .valid_out(valid_out),
    .col_out(col_out), .PE_rst_o(PE_rst_o), .busy_o(busy_o),
    .chunk_done_o(chunk_done_o), .done_o(done_o)
  );
  logic [BP_WIDTH-1:0] qmem [1024];
  logic [BP_WIDTH-1:0] tmem [1024];
  always @(posedge clk) begin
    q_data_i <= qmem[q_addr_o];
    t_data_i <= tmem[t_addr_o];
  end
  int n_chk = 0, n_fail = 0;
  logic [5:0]          ef [2048];
  logic [BP_WIDTH-1:0] es [2048];
  logic [BP_WIDTH-1:0] et [2048];
  int                  ecol [2048];
  logic [BP_WIDTH-1:0] last_s = '0, last_t = '0;
  typedef struct { int lq; int lt; int total; int chunks; } vec_t;
  vec_t tbl [6];
  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask
  function automatic int flags();
    return {26'd0, s_update_out, valid_out, ~PE_rst_o, chunk_done_o, done_o, busy_o};
  endfunction
  task automatic chk_idle(input string nm);
    chk({nm, "_flags"}, 0, flags(), 0);
    chk({nm, "_s_out"}, 0, int'(s_out), 0);
    chk({nm, "_t_out"}, 0, int'(t_out), 0);
    chk({nm, "_col"}, 0, int'(col_out), 0);
    chk({nm, "_addr"}, 0, int'({q_addr_o, t_addr_o}), 0);
  endtask
  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      qmem[i] = BP_WIDTH'($urandom_range(0, 4));
      tmem[i] = BP_WIDTH'($urandom_range(0, 4));
    end
  endtask
  // Model: chunk k starts with its CRST cycle at o; bases appear 2 cycles after CRST / 3 after LOAD ends.
  task automatic run(input int lq, input int lt, input int restart_at, input int abort_at,
                     output int done_cyc, output int n_cd);
    int o, total, lk, b, nch, len;
    logic [BP_WIDTH-1:0] s_cur, t_cur;
    nch = (lq + N_PE - 1) / N_PE;
    total = 0;
    for (int k = 0; k < nch; k++) total += ((lq - k * N_PE < N_PE) ? lq - k * N_PE : N_PE) + lt + DRAIN_CYCLES + 3;
    for (int c = 0; c <= total + 1; c++) begin
      ef[c] = '0; es[c] = '0; et[c] = '0; ecol[c] = 0;
    end
    o = 1;
    for (int k = 0; k < nch; k++) begin
      b = k * N_PE;
      lk = (lq - b < N_PE) ? lq - b : N_PE;
      len = lk + lt + DRAIN_CYCLES + 3;
      for (int c = o; c < o + len; c++) begin ef[c][0] = 1'b1; ecol[c] = b; end
      ef[o][3] = 1'b1;
      for (int i = 0; i < lk; i++) begin ef[o + 2 + i][5] = 1'b1; es[o + 2 + i] = qmem[b + lk - 1 - i]; end
      for (int j = 0; j < lt; j++) begin ef[o + lk + 3 + j][4] = 1'b1; et[o + lk + 3 + j] = tmem[j]; end
      ef[o + len - 1][2] = 1'b1;
      o += len;
    end
    ef[total][1] = 1'b1;
    s_cur = last_s;
    t_cur = last_t;
    for (int c = 1; c <= total + 1; c++) begin
      if (ef[c][5]) s_cur = es[c]; else es[c] = s_cur;
      if (ef[c][4]) t_cur = et[c]; else et[c] = t_cur;
    end
    @(negedge clk);
    query_len_i = AW'(lq);
    target_len_i = AW'(lt);
    start_i = 1'b1;
    done_cyc = -1;
    n_cd = 0;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      start_i = (c == restart_at);
      if (abort_at > 0 && c == abort_at + 1) begin
        chk_idle("abort");
        reset_i = 1'b0;
        s_cur = '0;
        t_cur = '0;
        break;
      end
      chk("flags", c, flags(), int'(ef[c]));
      chk("s_out", c, int'(s_out), int'(es[c]));
      chk("t_out", c, int'(t_out), int'(et[c]));
      if (ef[c][0]) chk("col_out", c, int'(col_out), ecol[c]);
      if (done_o && done_cyc < 0) done_cyc = c;
      if (chunk_done_o) n_cd++;
      if (c == abort_at) reset_i = 1'b1;
    end
    last_s = s_cur;
    last_t = t_cur;
  endtask
`ifdef SW_FEEDER_STALL_EN
  task automatic run_stall();
    logic [BP_WIDTH-1:0] xs[$], xt[$], os[$], ot[$];
    int total, lk, dc, ov;
    total = 0;
    for (int k = 0; k < 2; k++) begin
      lk = (40 - k * N_PE < N_PE) ? 40 - k * N_PE : N_PE;
      for (int i = lk - 1; i >= 0; i--) xs.push_back(qmem[k * N_PE + i]);
      for (int j = 0; j < 10; j++) xt.push_back(tmem[j]);
      total += lk + 10 + DRAIN_CYCLES + 3;
    end
    @(negedge clk);
    query_len_i = AW'(40);
    target_len_i = AW'(10);
    start_i = 1'b1;
    dc = -1;
    ov = 0;
    for (int c = 1; c <= total + 8; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (s_update_out) os.push_back(s_out);
      if (valid_out) ot.push_back(t_out);
      if (s_update_out && valid_out) ov++;
      if (done_o && dc < 0) dc = c;
      stall_i = (c >= 8 && c <= 10) || (c >= 41 && c <= 43);
    end
    chk("stall_overlap", 0, ov, 0);
    chk("stall_s_count", 0, os.size(), xs.size());
    chk("stall_t_count", 0, ot.size(), xt.size());
    for (int i = 0; i < xs.size() && i < os.size(); i++) chk("stall_s_base", i, int'(os[i]), int'(xs[i]));
    for (int i = 0; i < xt.size() && i < ot.size(); i++) chk("stall_t_base", i, int'(ot[i]), int'(xt[i]));
    chk("stall_done_cycle", 0, dc, total + 6);
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, n, lq, lt, exp_total;
    tbl[0] = '{4, 5, 46, 1};
    tbl[1] = '{1, 1, 39, 1};
    tbl[2] = '{70, 7, 202, 3};
    tbl[3] = '{32, 3, 72, 1};
    tbl[4] = '{33, 2, 111, 2};
    tbl[5] = '{64, 1, 140, 2};
    reset_i = 1'b1;
    start_i = 1'b0;
    query_len_i = '0;
    target_len_i = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset_i = 1'b0;
    for (int v = 0; v < 6; v++) begin
      fill_mem();
      if (v == 0) begin
        qmem[0] = BASE_A; qmem[1] = BASE_C; qmem[2] = BASE_G; qmem[3] = BASE_T;
      end
      run(tbl[v].lq, tbl[v].lt, 0, 0, d, n);
      chk("tbl_done_cycle", v, d, tbl[v].total);
      chk("tbl_chunks", v, n, tbl[v].chunks);
    end
    fill_mem();
    run(70, 7, 37, 0, d, n);
    chk("restart_done_cycle", 0, d, 202);
    chk("restart_chunks", 0, n, 3);
    run(70, 7, 0, 37, d, n);
    run(10, 4, 0, 0, d, n);
    chk("after_abort_done_cycle", 0, d, 51);
    chk("after_abort_chunks", 0, n, 1);
    for (int r = 0; r < 4; r++) begin
      fill_mem();
      lq = $urandom_range(1, 100);
      lt = $urandom_range(1, 40);
      exp_total = 0;
      for (int k = 0; k * N_PE < lq; k++) exp_total += 1 + ((lq - k * N_PE < N_PE) ? lq - k * N_PE : N_PE) + 1 + lt + DRAIN_CYCLES + 1;
      run(lq, lt, 0, 0, d, n);
      chk("rand_done_cycle", r, d, exp_total);
      chk("rand_chunks", r, n, (lq + N_PE - 1) / N_PE);
    end
`ifdef SW_FEEDER_STALL_EN
    fill_mem();
    run_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
